bus_trace_fifo: RTL and testbench

//   Captures one record per completed 68000 bus cycle (RW, UDS, LDS, ADDR, DATA) into a FIFO.

---
 rtl/bus_trace_fifo.sv | 178 +++++++++++++++++
 tb/tb_bus_trace_fifo.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_trace_fifo.sv
// Bus-cycle trace FIFO: one {WR,UDS,LDS,ADDR,DATA} record per completed 68000 bus cycle,
// show-ahead read-out. Optional address-window filter enabled by defining TRACE_FILTER_EN.
module bus_trace_fifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int ADDR_W     = 24,
    parameter int DATA_W     = 16
) (
    input  logic                    CPUCLK_IN,
    input  logic                    RESET_n_IN,
    input  logic                    AS_IN,
    input  logic                    WR_IN,
    input  logic                    UDS_IN,
    input  logic                    LDS_IN,
    input  logic                    DTACK_IN,
    input  logic [ADDR_W-1:0]       ADDR_IN,
    input  logic [DATA_W-1:0]       DATA_IN,
`ifdef TRACE_FILTER_EN
    input  logic [ADDR_W-1:0]       FLT_LO_IN,
    input  logic [ADDR_W-1:0]       FLT_HI_IN,
`endif
    input  logic                    TRACE_EN_IN,
    input  logic                    CLEAR_IN,
    input  logic                    POP_IN,
    output logic [3+ADDR_W+DATA_W-1:0] ENTRY_OUT,
    output logic                    VALID_OUT,
    output logic [DEPTH_LOG2:0]     COUNT_OUT,
    output logic                    OVERFLOW_OUT,
    output logic [7:0]              DROPPED_OUT
);

    localparam int ENTRY_W = 3 + ADDR_W + DATA_W;
    localparam int DEPTH   = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2:0]   CNT_ZERO = {(DEPTH_LOG2+1){1'b0}};
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2-1:0] PTR_ZERO = {DEPTH_LOG2{1'b0}};
    localparam logic [ENTRY_W-1:0]    ENTRY_ZERO = {ENTRY_W{1'b0}};

    logic [ENTRY_W-1:0]    mem_r [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_r;
    logic [DEPTH_LOG2-1:0] rd_ptr_r;
    logic [DEPTH_LOG2:0]   count_r;
    logic                  armed_r;
    logic                  overflow_r;
    logic [7:0]            dropped_r;
    logic [ENTRY_W-1:0]    entry_r;

    logic                  filter_ok_s;
    logic                  capture_s;
    logic                  full_s;
    logic                  empty_s;
    logic                  pop_s;
    logic                  push_s;
    logic                  drop_s;
    logic                  armed_nxt_s;
    logic [ENTRY_W-1:0]    rec_s;
    logic [DEPTH_LOG2-1:0] wr_ptr_nxt_s;
    logic [DEPTH_LOG2-1:0] rd_ptr_nxt_s;
    logic [DEPTH_LOG2:0]   count_nxt_s;
    logic [ENTRY_W-1:0]    head_nxt_s;

    // Address-window qualification of the current cycle
    always_comb begin
        filter_ok_s = 1'b1;
`ifdef TRACE_FILTER_EN
        if ((ADDR_IN >= FLT_LO_IN) && (ADDR_IN <= FLT_HI_IN)) begin
            filter_ok_s = 1'b1;
        end else begin
            filter_ok_s = 1'b0;
        end
`endif
    end

    // Capture/pop/push/drop decisions; clear suppresses every FIFO update
    always_comb begin
        rec_s     = {WR_IN, UDS_IN, LDS_IN, ADDR_IN, DATA_IN};
        full_s    = count_r[DEPTH_LOG2];
        empty_s   = (count_r == CNT_ZERO);
        capture_s = armed_r & AS_IN & DTACK_IN & TRACE_EN_IN & filter_ok_s;
        pop_s     = POP_IN & ~empty_s & ~CLEAR_IN;
        push_s    = capture_s & ~CLEAR_IN & (~full_s | pop_s);
        drop_s    = capture_s & ~CLEAR_IN & full_s & ~pop_s;
    end

    // Armed rises while AS is idle and is consumed by the first acknowledged strobe
    always_comb begin
        armed_nxt_s = armed_r;
        if (!AS_IN) begin
            armed_nxt_s = 1'b1;
        end else if (DTACK_IN) begin
            armed_nxt_s = 1'b0;
        end else begin
            armed_nxt_s = armed_r;
        end
    end

    // Next pointers and occupancy
    always_comb begin
        wr_ptr_nxt_s = wr_ptr_r;
        rd_ptr_nxt_s = rd_ptr_r;
        count_nxt_s  = count_r;
        if (push_s) begin
            wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
        end else begin
            wr_ptr_nxt_s = wr_ptr_r;
        end
        if (pop_s) begin
            rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE;
            2'b01:   count_nxt_s = count_r - CNT_ONE;
            default: count_nxt_s = count_r;
        endcase
    end

    // Next head record; the slot being written this edge must bypass the array
    always_comb begin
        head_nxt_s = ENTRY_ZERO;
        if (count_nxt_s == CNT_ZERO) begin
            head_nxt_s = ENTRY_ZERO;
        end else if (push_s && (rd_ptr_nxt_s == wr_ptr_r)) begin
            head_nxt_s = rec_s;
        end else begin
            head_nxt_s = mem_r[rd_ptr_nxt_s];
        end
    end

    // Record storage
    always_ff @(posedge CPUCLK_IN) begin
        if (RESET_n_IN && push_s) begin
            mem_r[wr_ptr_r] <= rec_s;
        end
    end

    // Control state, occupancy, overflow tracking and registered head
    always_ff @(posedge CPUCLK_IN) begin
        if (!RESET_n_IN) begin
            wr_ptr_r   <= PTR_ZERO;
            rd_ptr_r   <= PTR_ZERO;
            count_r    <= CNT_ZERO;
            armed_r    <= 1'b0;
            overflow_r <= 1'b0;
            dropped_r  <= 8'd0;
            entry_r    <= ENTRY_ZERO;
        end else begin
            armed_r <= armed_nxt_s;
            if (CLEAR_IN) begin
                wr_ptr_r   <= PTR_ZERO;
                rd_ptr_r   <= PTR_ZERO;
                count_r    <= CNT_ZERO;
                overflow_r <= 1'b0;
                dropped_r  <= 8'd0;
                entry_r    <= ENTRY_ZERO;
            end else begin
                wr_ptr_r <= wr_ptr_nxt_s;
                rd_ptr_r <= rd_ptr_nxt_s;
                count_r  <= count_nxt_s;
                entry_r  <= head_nxt_s;
                if (drop_s) begin
                    overflow_r <= 1'b1;
                    if (dropped_r != 8'hFF) begin
                        dropped_r <= dropped_r + 8'd1;
                    end
                end
            end
        end
    end

    assign ENTRY_OUT    = entry_r;
    assign VALID_OUT    = (count_r != CNT_ZERO);
    assign COUNT_OUT    = count_r;
    assign OVERFLOW_OUT = overflow_r;
    assign DROPPED_OUT  = dropped_r;

endmodule

// File: tb/tb_bus_trace_fifo.sv
// Self-checking bench for bus_trace_fifo: directed table, corner sequences, and random
// traffic against a queue-based reference model. Filter checks run when TRACE_FILTER_EN is defined.
module tb_bus_trace_fifo;

    logic        clk = 1'b0;
    logic        rst_n, as_v, wr, uds, lds, dtack, en, clr, pop;
    logic [23:0] addr;
    logic [15:0] data;
`ifdef TRACE_FILTER_EN
    logic [23:0] flt_lo, flt_hi;
`endif
    logic [42:0] entry;
    logic        valid;
    logic [4:0]  count;
    logic        ovf;
    logic [7:0]  dropped;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [42:0] q[$];
    bit          m_armed;
    bit          m_ovf;
    int          m_dropped;

    always #5 clk = ~clk;

    bus_trace_fifo dut (
        .CPUCLK_IN    (clk),
        .RESET_n_IN   (rst_n),
        .AS_IN        (as_v),
        .WR_IN        (wr),
        .UDS_IN       (uds),
        .LDS_IN       (lds),
        .DTACK_IN     (dtack),
        .ADDR_IN      (addr),
        .DATA_IN      (data),
`ifdef TRACE_FILTER_EN
        .FLT_LO_IN    (flt_lo),
        .FLT_HI_IN    (flt_hi),
`endif
        .TRACE_EN_IN  (en),
        .CLEAR_IN     (clr),
        .POP_IN       (pop),
        .ENTRY_OUT    (entry),
        .VALID_OUT    (valid),
        .COUNT_OUT    (count),
        .OVERFLOW_OUT (ovf),
        .DROPPED_OUT  (dropped)
    );

    function automatic void check(string name, logic [63:0] got, logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, got, want, $time);
        end
    endfunction

    function automatic bit in_window(logic [23:0] a);
`ifdef TRACE_FILTER_EN
        return (a >= flt_lo) && (a <= flt_hi);
`else
        return (a == a);
`endif
    endfunction

    // One clock edge of the reference behaviour, using the inputs held across the edge
    function automatic void model_edge();
        bit cap;
        if (!rst_n) begin
            q.delete();
            m_armed   = 1'b0;
            m_ovf     = 1'b0;
            m_dropped = 0;
            return;
        end
        cap = m_armed && as_v && dtack && en && in_window(addr);
        if (clr) begin
            q.delete();
            m_ovf     = 1'b0;
            m_dropped = 0;
        end else begin
            if (pop && q.size() > 0) void'(q.pop_front());
            if (cap) begin
                if (q.size() < 16) q.push_back({wr, uds, lds, addr, data});
                else begin
                    m_ovf = 1'b1;
                    if (m_dropped < 255) m_dropped++;
                end
            end
        end
        if (!as_v) m_armed = 1'b1;
        else if (dtack) m_armed = 1'b0;
    endfunction

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("model_count", 64'(count), 64'(q.size()));
        check("model_valid", 64'(valid), 64'(q.size() != 0));
        check("model_entry", 64'(entry), (q.size() != 0) ? 64'(q[0]) : 64'd0);
        check("model_overflow", 64'(ovf), 64'(m_ovf));
        check("model_dropped", 64'(dropped), 64'(m_dropped));
    endtask

    task automatic bus_cycle(input logic [23:0] a, input logic [15:0] d,
                             input logic w, input logic u, input logic l,
                             input logic pop_ack, input logic clr_ack);
        addr = a; data = d; wr = w; uds = u; lds = l;
        as_v = 1'b1; dtack = 1'b0;
        step();
        dtack = 1'b1; pop = pop_ack; clr = clr_ack;
        step();
        pop = 1'b0; clr = 1'b0; as_v = 1'b0; dtack = 1'b0;
        step();
    endtask

    typedef struct {
        logic        rst_n, as_v, dtack, pop;
        logic [23:0] addr;
        logic [15:0] data;
        int          exp_count;
        logic        exp_valid;
        logic [42:0] exp_entry;
    } vec_t;

    function automatic vec_t mk(logic r, logic a, logic d, logic p, int ec, logic ev, logic [42:0] ee);
        vec_t v;
        v.rst_n = r; v.as_v = a; v.dtack = d; v.pop = p;
        v.addr = 24'h00F000; v.data = 16'h1234;
        v.exp_count = ec; v.exp_valid = ev; v.exp_entry = ee;
        return v;
    endfunction

    initial begin
        vec_t        vecs[12];
        logic [42:0] rec_f000;
        logic [42:0] rec_new;

        rec_f000 = {3'b111, 24'h00F000, 16'h1234};
        rec_new  = {3'b111, 24'hABCDEF, 16'h5A5A};
        // reset with a cycle in progress, arming, a write cycle holding DTACK 3 edges, pops
        vecs[0]  = mk(1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0, 43'd0);
        vecs[1]  = mk(1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0, 43'd0);
        vecs[2]  = mk(1'b1, 1'b1, 1'b1, 1'b0, 0, 1'b0, 43'd0);
        vecs[3]  = mk(1'b1, 1'b1, 1'b1, 1'b0, 0, 1'b0, 43'd0);
        vecs[4]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 43'd0);
        vecs[5]  = mk(1'b1, 1'b0, 1'b0, 1'b1, 0, 1'b0, 43'd0);
        vecs[6]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0, 43'd0);
        vecs[7]  = mk(1'b1, 1'b1, 1'b1, 1'b0, 1, 1'b1, rec_f000);
        vecs[8]  = mk(1'b1, 1'b1, 1'b1, 1'b0, 1, 1'b1, rec_f000);
        vecs[9]  = mk(1'b1, 1'b1, 1'b1, 1'b0, 1, 1'b1, rec_f000);
        vecs[10] = mk(1'b1, 1'b0, 1'b0, 1'b0, 1, 1'b1, rec_f000);
        vecs[11] = mk(1'b1, 1'b0, 1'b0, 1'b1, 0, 1'b0, 43'd0);

        wr = 1'b1; uds = 1'b1; lds = 1'b1; en = 1'b1; clr = 1'b0;
        rst_n = 1'b0; as_v = 1'b1; dtack = 1'b1; pop = 1'b0;
        addr = 24'h0; data = 16'h0;
`ifdef TRACE_FILTER_EN
        flt_lo = 24'h000000; flt_hi = 24'hFFFFFF;
`endif
        for (int i = 0; i < 12; i++) begin
            rst_n = vecs[i].rst_n; as_v = vecs[i].as_v; dtack = vecs[i].dtack;
            pop = vecs[i].pop; addr = vecs[i].addr; data = vecs[i].data;
            step();
            check($sformatf("vec%0d_count", i), 64'(count), 64'(vecs[i].exp_count));
            check($sformatf("vec%0d_valid", i), 64'(valid), 64'(vecs[i].exp_valid));
            check($sformatf("vec%0d_entry", i), 64'(entry), 64'(vecs[i].exp_entry));
        end
        pop = 1'b0;

        // 19 cycles into an empty FIFO without pops
        for (int i = 0; i < 19; i++)
            bus_cycle(24'h010000 + 24'(i), 16'hA000 + 16'(i), i[0], 1'b1, i[1], 1'b0, 1'b0);
        check("fill_count", 64'(count), 64'd16);
        check("fill_overflow", 64'(ovf), 64'd1);
        check("fill_dropped", 64'(dropped), 64'd3);
        check("fill_head", 64'(entry), 64'({1'b0, 1'b1, 1'b0, 24'h010000, 16'hA000}));

        // drop counter saturation
        for (int i = 0; i < 253; i++)
            bus_cycle(24'h020000 + 24'(i), 16'(i), 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        check("sat_dropped", 64'(dropped), 64'd255);
        check("sat_count", 64'(count), 64'd16);

        // full: capture and pop on the same edge
        bus_cycle(24'hABCDEF, 16'h5A5A, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        check("fullpp_count", 64'(count), 64'd16);
        check("fullpp_dropped", 64'(dropped), 64'd255);
        pop = 1'b1;
        for (int i = 0; i < 15; i++) step();
        pop = 1'b0;
        check("fullpp_last_entry", 64'(entry), 64'(rec_new));
        check("fullpp_last_count", 64'(count), 64'd1);
        pop = 1'b1;
        step();
        pop = 1'b0;
        check("drain_valid", 64'(valid), 64'd0);

        // clear beats simultaneous capture and pop
        for (int i = 0; i < 5; i++)
            bus_cycle(24'h030000 + 24'(i), 16'h0F00 + 16'(i), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("five_count", 64'(count), 64'd5);
        bus_cycle(24'h031000, 16'hBEEF, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        check("clear_count", 64'(count), 64'd0);
        check("clear_valid", 64'(valid), 64'd0);
        check("clear_overflow", 64'(ovf), 64'd0);
        check("clear_dropped", 64'(dropped), 64'd0);

`ifdef TRACE_FILTER_EN
        flt_lo = 24'h100000; flt_hi = 24'h1FFFFF;
        bus_cycle(24'h0FFFFF, 16'h0001, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        bus_cycle(24'h100000, 16'h0002, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        bus_cycle(24'h1FFFFF, 16'h0003, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        bus_cycle(24'h200000, 16'h0004, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        check("filter_count", 64'(count), 64'd2);
        check("filter_dropped", 64'(dropped), 64'd0);
        check("filter_head", 64'(entry), 64'({3'b011, 24'h100000, 16'h0002}));
        flt_lo = 24'h080000; flt_hi = 24'hC00000;
`endif

        // random traffic; pop rate low first so the FIFO fills, then high so it drains
        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(0, 199) != 0);
            as_v  = ($urandom_range(0, 3) != 0);
            dtack = $urandom_range(0, 1) == 1;
            en    = ($urandom_range(0, 7) != 0);
            clr   = ($urandom_range(0, 99) == 0);
            pop   = (i < 1500) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 1) == 0);
            wr    = $urandom_range(0, 1) == 1;
            uds   = $urandom_range(0, 1) == 1;
            lds   = $urandom_range(0, 1) == 1;
            addr  = 24'($urandom);
            data  = 16'($urandom);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
